// File: rtl/var_bw_mac_if.sv
// Handshake bundle between the multiplier, the accumulation stage and its consumer.
// The slave side is the accumulator; the master side is the upstream and downstream logic.
interface var_bw_mac_if #(
  parameter int GUARD = 8,
  parameter int CNT_W = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 para_mode;
  logic [31:0]          p;
  logic                 last;
  logic                 out_valid;
  logic                 out_ready;
  logic [32+GUARD-1:0]  acc_out;
  logic [CNT_W-1:0]     cnt_out;
  logic                 mode_out;
  logic                 ovf;

  modport master (
    output in_valid, para_mode, p, last, out_ready,
    input  in_ready, out_valid, acc_out, cnt_out, mode_out, ovf
  );

  modport slave (
    input  in_valid, para_mode, p, last, out_ready,
    output in_ready, out_valid, acc_out, cnt_out, mode_out, ovf
  );
endinterface

// File: rtl/var_bw_mac_acc.sv
// Packet accumulator for the variable bit-width multiplier: one 40-bit-ish sum or two
// independent 16-bit lanes. Define VAR_BW_MAC_SAT_EN to clamp on overflow instead of wrapping.
module var_bw_mac_acc #(
  parameter int GUARD = 8,
  parameter int CNT_W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  var_bw_mac_if.slave    bus
);
  localparam int ACC_W  = 32 + GUARD;
  localparam int LANE_W = 16 + GUARD / 2;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t              state_reg, state_next;
  logic [ACC_W-1:0]    acc_reg, acc_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic                mode_reg, mode_next;
  logic                ovf_reg, ovf_next;

  logic                beat_fire;
  logic                out_fire;
  logic                in_ready_int;
  logic                out_valid_int;

  logic [ACC_W:0]      wide_sum;
  logic [ACC_W-1:0]    wide_res;
  logic                wide_carry;
  logic [ACC_W-1:0]    wide_load;
  logic [2*LANE_W-1:0] lane_res;
  logic [2*LANE_W-1:0] lane_load;
  logic [1:0]          lane_carry;

  assign beat_fire = bus.in_valid && in_ready_int;
  assign out_fire  = out_valid_int && bus.out_ready;

  // Full-width path: zero-extended product added to the whole accumulator.
  assign wide_sum   = {1'b0, acc_reg} + {{(ACC_W-31){1'b0}}, bus.p};
  assign wide_carry = wide_sum[ACC_W];
  assign wide_load  = {{GUARD{1'b0}}, bus.p};
`ifdef VAR_BW_MAC_SAT_EN
  assign wide_res   = wide_carry ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
  assign wide_res   = wide_sum[ACC_W-1:0];
`endif

  // Packed path: lane 0 takes p[15:0], lane 1 takes p[31:16], no carry between them.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [LANE_W:0] sum;
      assign sum = {1'b0, acc_reg[gi*LANE_W +: LANE_W]}
                 + {{(LANE_W-15){1'b0}}, bus.p[gi*16 +: 16]};
      assign lane_carry[gi] = sum[LANE_W];
      assign lane_load[gi*LANE_W +: LANE_W] = {{(LANE_W-16){1'b0}}, bus.p[gi*16 +: 16]};
`ifdef VAR_BW_MAC_SAT_EN
      assign lane_res[gi*LANE_W +: LANE_W] = sum[LANE_W] ? {LANE_W{1'b1}} : sum[LANE_W-1:0];
`else
      assign lane_res[gi*LANE_W +: LANE_W] = sum[LANE_W-1:0];
`endif
    end
  endgenerate

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (beat_fire) state_next = bus.last ? DONE : ACC;
      ACC:     if (beat_fire && bus.last) state_next = DONE;
      DONE:    if (out_fire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: handshake flags come from the state alone
  always_comb begin
    in_ready_int  = 1'b1;
    out_valid_int = 1'b0;
    case (state_reg)
      IDLE:    in_ready_int = 1'b1;
      ACC:     in_ready_int = 1'b1;
      DONE: begin
        in_ready_int  = 1'b0;
        out_valid_int = 1'b1;
      end
      default: in_ready_int = 1'b1;
    endcase
  end

  // Datapath next values; the first beat of a packet loads rather than adds
  always_comb begin
    acc_next  = acc_reg;
    cnt_next  = cnt_reg;
    mode_next = mode_reg;
    ovf_next  = ovf_reg;
    if (beat_fire) begin
      if (state_reg == IDLE) begin
        acc_next  = bus.para_mode ? lane_load : wide_load;
        cnt_next  = {{(CNT_W-1){1'b0}}, 1'b1};
        mode_next = bus.para_mode;
        ovf_next  = 1'b0;
      end else begin
        acc_next  = mode_reg ? lane_res : wide_res;
        cnt_next  = (&cnt_reg) ? cnt_reg : cnt_reg + 1'b1;
        ovf_next  = ovf_reg | (mode_reg ? (|lane_carry) : wide_carry);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      mode_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      acc_reg  <= acc_next;
      cnt_reg  <= cnt_next;
      mode_reg <= mode_next;
      ovf_reg  <= ovf_next;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_int;
  assign bus.acc_out   = acc_reg;
  assign bus.cnt_out   = cnt_reg;
  assign bus.mode_out  = mode_reg;
  assign bus.ovf       = ovf_reg;
endmodule
